// File: rtl/code_lock_pkg.sv
// code_lock_pkg: state encodings and default parameters for the code lock controller
package code_lock_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE    = 3'd0;
  localparam state_t ARMED   = 3'd1;
  localparam state_t OPEN    = 3'd2;
  localparam state_t FAIL    = 3'd3;
  localparam state_t LOCKOUT = 3'd4;
  localparam int ATTEMPT_CYCLES_DEF = 64;
  localparam int OPEN_CYCLES_DEF    = 16;
  localparam int LOCK_CYCLES_DEF    = 256;
  localparam int MAX_FAIL_DEF       = 3;
  localparam int TMR_W_DEF          = 9;
  localparam int FAIL_W_DEF         = 2;
endpackage

// File: rtl/code_lock_timer.sv
// code_lock_timer: shared down-counter with load, enable and zero flag
// Ports: clk_i clock, rst_ni sync active-low reset, load_i/load_val_i load value,
//        en_i decrement enable, zero_o count equals zero
module code_lock_timer #(
  parameter int TMR_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);
  logic [TMR_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : en_i ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/code_lock_controller.sv
// code_lock_controller: gates Start into the code detector, times attempts, counts failures, drives lockout and unlock
// Ports: Clk clock, Rst sync active-low reset, Start raw button, U code detected,
//        DetStart gated start, DetRst detector reset, Unlock door release, Locked lockout,
//        Busy not idle, FailCnt consecutive failures.
// Option CODE_LOCK_ALARM_EN adds AlarmClr input and registered Alarm output.
module code_lock_controller
  import code_lock_pkg::*;
#(
  parameter int ATTEMPT_CYCLES = ATTEMPT_CYCLES_DEF,
  parameter int OPEN_CYCLES    = OPEN_CYCLES_DEF,
  parameter int LOCK_CYCLES    = LOCK_CYCLES_DEF,
  parameter int MAX_FAIL       = MAX_FAIL_DEF,
  parameter int TMR_W          = TMR_W_DEF,
  parameter int FAIL_W         = FAIL_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              U,
  output logic              DetStart,
  output logic              DetRst,
  output logic              Unlock,
  output logic              Locked,
  output logic              Busy,
`ifdef CODE_LOCK_ALARM_EN
  input  logic              AlarmClr,
  output logic              Alarm,
`endif
  output logic [FAIL_W-1:0] FailCnt
);
  state_t state_q, state_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [FAIL_W:0] fail_inc;
  logic tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val;
  // one extra bit so the MAX_FAIL comparison cannot be fooled by wrap-around
  assign fail_inc = {1'b0, fail_q} + 1'b1;
  always_comb begin
    state_d  = state_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        state_d  = ARMED;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(ATTEMPT_CYCLES - 1);
      end
      // success takes priority over the timeout on the final cycle
      ARMED: if (U) begin
        state_d  = OPEN;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(OPEN_CYCLES - 1);
        fail_d   = '0;
      end else if (tmr_zero) state_d = FAIL;
      else tmr_en = 1'b1;
      FAIL: if (fail_inc == (FAIL_W+1)'(MAX_FAIL)) begin
        state_d  = LOCKOUT;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(LOCK_CYCLES - 1);
        fail_d   = FAIL_W'(MAX_FAIL);
      end else begin
        state_d = IDLE;
        fail_d  = fail_inc[FAIL_W-1:0];
      end
      OPEN: if (tmr_zero) state_d = IDLE;
      else tmr_en = 1'b1;
      LOCKOUT: if (tmr_zero) begin
        state_d = IDLE;
        fail_d  = '0;
      end else tmr_en = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end
  code_lock_timer #(.TMR_W(TMR_W)) u_timer (
    .clk_i      (Clk),
    .rst_ni     (Rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );
`ifdef CODE_LOCK_ALARM_EN
  logic alarm_q, alarm_d;
  always_comb alarm_d = (state_q == FAIL && state_d == LOCKOUT) ? 1'b1 : AlarmClr ? 1'b0 : alarm_q;
  always_ff @(posedge Clk) begin
    if (!Rst) alarm_q <= 1'b0;
    else alarm_q <= alarm_d;
  end
  assign Alarm = alarm_q;
`endif
  assign DetStart = Start & (state_q == IDLE);
  assign DetRst   = ~Rst | (state_q == FAIL) | (state_q == LOCKOUT);
  assign Unlock   = (state_q == OPEN);
  assign Locked   = (state_q == LOCKOUT);
  assign Busy     = (state_q != IDLE);
  assign FailCnt  = fail_q;
endmodule

// File: tb/tb_code_lock_controller.sv
// tb_code_lock_controller: table-driven and directed checks of code_lock_controller
module tb_code_lock_controller;
  logic Clk, Rst, Start, U;
  logic DetStart, DetRst, Unlock, Locked, Busy;
  logic [1:0] FailCnt;
`ifdef CODE_LOCK_ALARM_EN
  logic AlarmClr, Alarm;
`endif
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic rst, start, u;
    logic ds, dr, ul, lk, bs;
    logic [1:0] fc;
  } vec_t;
  vec_t vecs[$];

  code_lock_controller #(
    .ATTEMPT_CYCLES(8), .OPEN_CYCLES(4), .LOCK_CYCLES(10),
    .MAX_FAIL(3), .TMR_W(9), .FAIL_W(2)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .U(U),
    .DetStart(DetStart), .DetRst(DetRst), .Unlock(Unlock),
    .Locked(Locked), .Busy(Busy),
`ifdef CODE_LOCK_ALARM_EN
    .AlarmClr(AlarmClr), .Alarm(Alarm),
`endif
    .FailCnt(FailCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic u);
    @(negedge Clk);
    Rst = r;
    Start = s;
    U = u;
    #1;
  endtask

  task automatic add(input logic r, s, u, ds, dr, ul, lk, bs, input logic [1:0] fc, input int n);
    vec_t v;
    v = '{rst: r, start: s, u: u, ds: ds, dr: dr, ul: ul, lk: lk, bs: bs, fc: fc};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    Rst = 1'b0;
    Start = 1'b0;
    U = 1'b0;
`ifdef CODE_LOCK_ALARM_EN
    AlarmClr = 1'b0;
`endif
    add(0,0,0, 0,1,0,0,0, 2'd0, 1);
    add(1,0,0, 0,0,0,0,0, 2'd0, 1);
    add(1,1,0, 1,0,0,0,0, 2'd0, 1);
    add(1,0,0, 0,0,0,0,1, 2'd0, 1);
    add(1,1,0, 0,0,0,0,1, 2'd0, 1);
    add(1,0,0, 0,0,0,0,1, 2'd0, 3);
    add(1,0,1, 0,0,0,0,1, 2'd0, 1);
    add(1,0,0, 0,0,1,0,1, 2'd0, 1);
    add(1,0,1, 0,0,1,0,1, 2'd0, 1);
    add(1,1,0, 0,0,1,0,1, 2'd0, 1);
    add(1,0,0, 0,0,1,0,1, 2'd0, 1);
    add(1,0,0, 0,0,0,0,0, 2'd0, 1);
    for (int k = 0; k < 3; k++) begin
      add(1,1,0, 1,0,0,0,0, 2'(k), 1);
      add(1,0,0, 0,0,0,0,1, 2'(k), 8);
      add(1,0,0, 0,1,0,0,1, 2'(k), 1);
    end
    add(1,1,0, 0,1,0,1,1, 2'd3, 5);
    add(1,0,1, 0,1,0,1,1, 2'd3, 5);
    add(1,0,0, 0,0,0,0,0, 2'd0, 1);

    @(negedge Clk);
    #1;
    check("reset DetRst", 8'(DetRst), 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].u);
      check($sformatf("row%0d DetStart", i), 8'(DetStart), 8'(vecs[i].ds));
      check($sformatf("row%0d DetRst", i), 8'(DetRst), 8'(vecs[i].dr));
      check($sformatf("row%0d Unlock", i), 8'(Unlock), 8'(vecs[i].ul));
      check($sformatf("row%0d Locked", i), 8'(Locked), 8'(vecs[i].lk));
      check($sformatf("row%0d Busy", i), 8'(Busy), 8'(vecs[i].bs));
      check($sformatf("row%0d FailCnt", i), 8'(FailCnt), 8'(vecs[i].fc));
    end

`ifdef CODE_LOCK_ALARM_EN
    check("alarm after lockout", 8'(Alarm), 8'd1);
    step(1, 0, 0);
    check("alarm held", 8'(Alarm), 8'd1);
    AlarmClr = 1'b1;
    step(1, 0, 0);
    AlarmClr = 1'b0;
    step(1, 0, 0);
    check("alarm cleared", 8'(Alarm), 8'd0);
`endif

    step(1, 1, 0);
    check("t5 DetStart", 8'(DetStart), 8'd1);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0);
      check("t5 armed Busy", 8'(Busy), 8'd1);
    end
    step(1, 0, 1);
    check("t5 last armed DetRst", 8'(DetRst), 8'd0);
    step(1, 0, 0);
    check("t5 U at zero Unlock", 8'(Unlock), 8'd1);
    check("t5 U at zero DetRst", 8'(DetRst), 8'd0);
    step(0, 0, 0);
    check("t5 open2 Unlock", 8'(Unlock), 8'd1);
    check("t5 reset DetRst", 8'(DetRst), 8'd1);
    step(1, 0, 0);
    check("t5 abort Unlock", 8'(Unlock), 8'd0);
    check("t5 abort Busy", 8'(Busy), 8'd0);
    check("t5 abort FailCnt", 8'(FailCnt), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
